// File: rtl/window_tap_scanner.sv
// window_tap_scanner: raster-order generator of K x K padded-window tap coordinates
module window_tap_scanner #(
  parameter int IMG_W = 64,
  parameter int PAD = 2,
  parameter int K = 5,
  localparam int VW = $clog2(IMG_W + 2 * PAD),
  localparam int TW = $clog2(K * K),
  localparam int OW = $clog2(IMG_W),
  localparam int KW = $clog2(K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic [VW-1:0] virt_row,
  output logic [VW-1:0] virt_col,
  output logic [TW-1:0] tap_idx,
  output logic          win_first,
  output logic          win_last,
  output logic [OW-1:0] out_row,
  output logic [OW-1:0] out_col
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] kr, kc;
  logic hs, kc_end, kr_end, col_end, row_end, last;
  assign hs = tap_valid && tap_ready;
  assign kc_end = kc == KW'(K - 1);
  assign kr_end = kr == KW'(K - 1);
  assign col_end = out_col == OW'(IMG_W - 1);
  assign row_end = out_row == OW'(IMG_W - 1);
  assign last = kc_end && kr_end && col_end && row_end;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // next state: start only honoured in idle, final handshake retires the frame
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE && start) ? S_SCAN :
              (state == S_SCAN && hs && last) ? S_DONE :
              (state == S_DONE) ? S_IDLE : state;
  end
  // window/pixel counters; the final handshake leaves them on the last tap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kc <= '0;
      kr <= '0;
      out_col <= '0;
      out_row <= '0;
    end else if (state == S_IDLE && start) begin
      kc <= '0;
      kr <= '0;
      out_col <= '0;
      out_row <= '0;
    end else if (hs && !last) begin
      kc <= kc_end ? '0 : kc + 1'b1;
      if (kc_end) kr <= kr_end ? '0 : kr + 1'b1;
      if (kc_end && kr_end) out_col <= col_end ? '0 : out_col + 1'b1;
      if (kc_end && kr_end && col_end) out_row <= out_row + 1'b1;
    end
  assign busy = state == S_SCAN;
  assign tap_valid = state == S_SCAN;
  assign done = state == S_DONE;
  assign virt_row = VW'(out_row) + VW'(kr);
  assign virt_col = VW'(out_col) + VW'(kc);
  assign tap_idx = TW'(kr) * TW'(K) + TW'(kc);
  assign win_first = kr == '0 && kc == '0;
  assign win_last = kr_end && kc_end;
endmodule

// File: tb/tb_window_tap_scanner.sv
// tb_window_tap_scanner: randomized self-checking bench against an arithmetic tap-order model
`timescale 1ns/1ps
module tb_window_tap_scanner;
  localparam int IMG_W = 4, PAD = 2, K = 5;
  localparam int TOTAL = IMG_W * IMG_W * K * K;
  localparam int VW = $clog2(IMG_W + 2 * PAD), TW = $clog2(K * K), OW = $clog2(IMG_W);
  logic clk = 0, reset = 1, start = 0, tap_ready = 0;
  logic busy, done, tap_valid, win_first, win_last;
  logic [VW-1:0] virt_row, virt_col;
  logic [TW-1:0] tap_idx;
  logic [OW-1:0] out_row, out_col;
  int errors = 0, checks = 0, n = 0, cyc = 0, first_cyc = 0, vmax = 0, scan_cyc = 0;
  int w, t;
  bit full_rate = 0;
  typedef enum {M_IDLE, M_SCAN, M_DONE} mstate_t;
  mstate_t ms = M_IDLE;

  window_tap_scanner #(.IMG_W(IMG_W), .PAD(PAD), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .virt_row(virt_row), .virt_col(virt_col),
    .tap_idx(tap_idx), .win_first(win_first), .win_last(win_last),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tap %0d)", nm, act, exp, n);
    end
  endtask

  // downstream MMU: clamp padded coordinates into the image, then row-major address
  function automatic int phys(input int vr, input int vc);
    int r, c;
    r = vr - PAD; c = vc - PAD;
    r = r < 0 ? 0 : (r > IMG_W - 1 ? IMG_W - 1 : r);
    c = c < 0 ? 0 : (c > IMG_W - 1 ? IMG_W - 1 : c);
    return r * IMG_W + c;
  endfunction

  // reference: tap n of a frame is window n/(K*K), tap n%(K*K), windows in raster order
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", tap_valid, 0);
      chk("rst_vrow", virt_row, 0);
      chk("rst_vcol", virt_col, 0);
      chk("rst_idx", tap_idx, 0);
      chk("rst_orow", out_row, 0);
      chk("rst_ocol", out_col, 0);
      ms = M_IDLE; n = 0; vmax = 0;
    end else begin
      cyc++;
      chk("busy", busy, ms == M_SCAN);
      chk("valid", tap_valid, ms == M_SCAN);
      chk("done", done, ms == M_DONE);
      if (ms == M_SCAN) begin
        scan_cyc++;
        if (scan_cyc > 20 * TOTAL) begin
          $display("FAIL timeout: scan ran %0d cycles expected at most %0d", scan_cyc, 20 * TOTAL);
          $fatal(1);
        end
        w = n / (K * K); t = n % (K * K);
        chk("vrow", virt_row, w / IMG_W + t / K);
        chk("vcol", virt_col, w % IMG_W + t % K);
        chk("idx", tap_idx, t);
        chk("orow", out_row, w / IMG_W);
        chk("ocol", out_col, w % IMG_W);
        chk("wfirst", win_first, t == 0);
        chk("wlast", win_last, t == K * K - 1);
        if (n == 0) begin
          first_cyc = cyc;
          chk("t0_vrow", virt_row, 0);
          chk("t0_wfirst", win_first, 1);
        end
        if (n == 24) begin
          chk("t24_vrow", virt_row, 4);
          chk("t24_vcol", virt_col, 4);
          chk("t24_idx", tap_idx, 24);
          chk("t24_wlast", win_last, 1);
        end
        if (n == 25) begin
          chk("t25_vcol", virt_col, 1);
          chk("t25_ocol", out_col, 1);
        end
        if (n == TOTAL - 1) begin
          chk("tlast_vrow", virt_row, 7);
          chk("tlast_vcol", virt_col, 7);
          chk("tlast_idx", tap_idx, 24);
          chk("tlast_orow", out_row, 3);
        end
        if (virt_row > vmax) vmax = virt_row;
        if (virt_col > vmax) vmax = virt_col;
        if (virt_row == 1 && virt_col == 1) chk("mmu_1_1", phys(virt_row, virt_col), 0);
        if (virt_row == 7 && virt_col == 7) chk("mmu_7_7", phys(virt_row, virt_col), 15);
      end
      if (ms == M_DONE) begin
        chk("frame_taps", n, TOTAL);
        chk("max_virt", vmax, 7);
        if (full_rate) chk("done_latency", cyc - first_cyc, TOTAL);
      end
      case (ms)
        M_IDLE: if (start) begin ms = M_SCAN; n = 0; vmax = 0; scan_cyc = 0; end
        M_SCAN: if (tap_ready) begin n++; if (n == TOTAL) ms = M_DONE; end
        default: ms = M_IDLE;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit rnd, input bit mid_start, input bit done_start);
    full_rate = !rnd;
    tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 20 * TOTAL && !done; k++) begin
      tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = mid_start && n == 100;
      step();
    end
    start = done_start && done;
    step();
    start = 0;
    repeat (3) step();
  endtask

  initial begin
    repeat (3) step();
    reset = 0;
    step();
    run_frame(0, 0, 0);
    run_frame(1, 1, 1);
    full_rate = 0;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 20 * TOTAL && !(n == 162 && tap_valid); k++) begin
      tap_ready = 1'($urandom_range(0, 1));
      step();
    end
    tap_ready = 0;
    #1 reset = 1;
    repeat (2) step();
    reset = 0;
    step();
    run_frame(1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
